// File: rtl/adc_fifo_pkg.sv
// Shared constants for the ADC sample capture FIFO.
// Holds the capture FSM state encoding and the default sample width / FIFO depth.
// No ports; imported by adc_sync_fifo and adc_sample_fifo.
package adc_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

endpackage

// File: rtl/adc_sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers and occupancy counter.
// Ports: push/wr_data in (wr_ack says the write was taken), pop in, rd_data/rd_valid out
//   one cycle after an accepted pop, level/empty/full status, flush empties the FIFO.
// A push while full is refused unless a pop frees the slot in the same cycle.
import adc_fifo_pkg::*;

module adc_sync_fifo #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [AW:0]           level,
  output logic                  empty,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty  = (level == '0);
  assign full   = (level == (AW+1)'(DEPTH));
  // Full means non-empty, so a pop in the same cycle always frees a slot.
  assign do_pop  = !flush && pop && !empty;
  assign do_push = !flush && push && (!full || pop);
  assign wr_ack  = do_push;

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_pop;
      if (do_pop) begin
        // When full with a simultaneous push, wr_ptr == rd_ptr; the read sees the old entry.
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/adc_sample_fifo.sv
// ADC sample capture: arm/capture/done FSM in front of a sample FIFO.
// Ports: sample_in/sample_valid_in strobe, arm_in + capture_len_in (0 = continuous), clear_in,
//   rd_en_in pop with registered data_out/data_valid_out (1-cycle latency), level/empty/full,
//   sticky overflow_out, busy_out (CAPTURE), done_out (DONE).
// Option ADC_FIFO_WATERMARK_EN adds watermark_in and a registered irq_out.
// Samples arriving while full in CAPTURE are dropped and flagged; samples outside CAPTURE are ignored.
import adc_fifo_pkg::*;

module adc_sample_fifo #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  input  logic                  arm_in,
  input  logic [9:0]            capture_len_in,
  input  logic                  clear_in,
  input  logic                  rd_en_in,
`ifdef ADC_FIFO_WATERMARK_EN
  input  logic [AW:0]           watermark_in,
  output logic                  irq_out,
`endif
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic [AW:0]           level_out,
  output logic                  empty_out,
  output logic                  full_out,
  output logic                  overflow_out,
  output logic                  busy_out,
  output logic                  done_out
);

  logic [1:0] state;
  logic [9:0] cap_len;
  logic [9:0] acc_cnt;
  logic       cap_push;
  logic       wr_ack;

  assign cap_push = (state == ST_CAPTURE) && sample_valid_in;
  assign busy_out = (state == ST_CAPTURE);
  assign done_out = (state == ST_DONE);

  adc_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (clear_in),
    .push     (cap_push),
    .wr_data  (sample_in),
    .wr_ack   (wr_ack),
    .pop      (rd_en_in),
    .rd_data  (data_out),
    .rd_valid (data_valid_out),
    .level    (level_out),
    .empty    (empty_out),
    .full     (full_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cap_len      <= '0;
      acc_cnt      <= '0;
      overflow_out <= 1'b0;
    end else if (clear_in) begin
      state        <= ST_IDLE;
      acc_cnt      <= '0;
      overflow_out <= 1'b0;
    end else begin
      // A capture-state sample the FIFO refused is a drop.
      if (cap_push && !wr_ack) overflow_out <= 1'b1;
      if (arm_in) begin
        state   <= ST_CAPTURE;
        cap_len <= capture_len_in;
        acc_cnt <= '0;
      end else if (wr_ack) begin
        acc_cnt <= acc_cnt + 10'd1;
        if ((cap_len != 10'd0) && (acc_cnt + 10'd1 == cap_len)) state <= ST_DONE;
      end
    end
  end

`ifdef ADC_FIFO_WATERMARK_EN
  // Built from registered status, so irq_out lags level_out by one cycle.
  always_ff @(posedge clk) begin
    if (rst) irq_out <= 1'b0;
    else     irq_out <= ((level_out >= watermark_in) && (watermark_in != '0)) || done_out;
  end
`endif

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed bench for adc_sample_fifo (DATA_WIDTH 32, DEPTH 16).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Covers reset, length-limited capture, overflow, full push+pop, pointer wrap, arm/clear rules.
`timescale 1ns/1ps

module tb_adc_sample_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] sample_in;
  logic          sample_valid_in;
  logic          arm_in;
  logic [9:0]    capture_len_in;
  logic          clear_in;
  logic          rd_en_in;
  logic [DW-1:0] data_out;
  logic          data_valid_out;
  logic [AW:0]   level_out;
  logic          empty_out;
  logic          full_out;
  logic          overflow_out;
  logic          busy_out;
  logic          done_out;
`ifdef ADC_FIFO_WATERMARK_EN
  logic [AW:0]   watermark_in;
  logic          irq_out;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adc_sample_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .arm_in          (arm_in),
    .capture_len_in  (capture_len_in),
    .clear_in        (clear_in),
    .rd_en_in        (rd_en_in),
`ifdef ADC_FIFO_WATERMARK_EN
    .watermark_in    (watermark_in),
    .irq_out         (irq_out),
`endif
    .data_out        (data_out),
    .data_valid_out  (data_valid_out),
    .level_out       (level_out),
    .empty_out       (empty_out),
    .full_out        (full_out),
    .overflow_out    (overflow_out),
    .busy_out        (busy_out),
    .done_out        (done_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sample_valid_in = 1'b0;
    arm_in          = 1'b0;
    clear_in        = 1'b0;
    rd_en_in        = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] v);
    sample_in = v; sample_valid_in = 1'b1;
    step();
    sample_valid_in = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [DW-1:0] exp);
    rd_en_in = 1'b1;
    step();
    rd_en_in = 1'b0;
    check({tag, "_vld"}, data_valid_out, 1);
    check(tag, data_out, exp);
  endtask

  task automatic arm(input logic [9:0] len);
    arm_in = 1'b1; capture_len_in = len;
    step();
    arm_in = 1'b0;
  endtask

  task automatic clear();
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
  endtask

  initial begin
    idle_inputs();
    sample_in = '0; capture_len_in = '0;
`ifdef ADC_FIFO_WATERMARK_EN
    watermark_in = '0;
`endif
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_level", level_out, 0);
    check("rst_empty", empty_out, 1);
    check("rst_full", full_out, 0);
    check("rst_ovf", overflow_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_dvld", data_valid_out, 0);
    check("rst_dout", data_out, 0);

    // Samples in IDLE are ignored
    push(32'h55);
    check("idle_ignore_level", level_out, 0);

    // Length-4 capture with 6 samples offered
    arm(10'd4);
    check("cap_busy", busy_out, 1);
    for (int i = 0; i < 6; i++) push(32'hA0 + i);
    check("cap_done", done_out, 1);
    check("cap_busy_lo", busy_out, 0);
    check("cap_level", level_out, 4);
    check("cap_ovf", overflow_out, 0);
    for (int i = 0; i < 4; i++) pop_check("cap_data", 32'hA0 + i);
    check("cap_empty", empty_out, 1);

    // Reset mid-capture with level 5
    arm(10'd0);
    for (int i = 0; i < 5; i++) push(32'h10 + i);
    check("midrst_level5", level_out, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", busy_out, 0);
    check("midrst_done", done_out, 0);
    check("midrst_level", level_out, 0);
    check("midrst_empty", empty_out, 1);
    check("midrst_ovf", overflow_out, 0);

    // Continuous capture, 17 samples, no reads
    arm(10'd0);
    for (int i = 1; i <= 17; i++) push(i);
    check("ovf_full", full_out, 1);
    check("ovf_level", level_out, 16);
    check("ovf_flag", overflow_out, 1);
    check("ovf_busy", busy_out, 1);
    for (int i = 1; i <= 16; i++) pop_check("ovf_data", i);
    check("ovf_empty", empty_out, 1);
    rd_en_in = 1'b1;
    step();
    rd_en_in = 1'b0;
    check("empty_rd_vld", data_valid_out, 0);
    check("empty_rd_level", level_out, 0);

    // Clear returns to IDLE and drops the sticky flag
    clear();
    check("clr_ovf", overflow_out, 0);
    check("clr_busy", busy_out, 0);

    // Simultaneous push and pop while full
    arm(10'd0);
    for (int i = 0; i < 16; i++) push(32'h100 + i);
    check("sim_full", full_out, 1);
    sample_in = 32'h200; sample_valid_in = 1'b1; rd_en_in = 1'b1;
    step();
    sample_valid_in = 1'b0; rd_en_in = 1'b0;
    check("sim_vld", data_valid_out, 1);
    check("sim_data", data_out, 32'h100);
    check("sim_level", level_out, 16);
    check("sim_ovf", overflow_out, 0);
    for (int i = 1; i < 16; i++) pop_check("sim_drain", 32'h100 + i);
    pop_check("sim_drain_last", 32'h200);
    check("sim_empty", empty_out, 1);

    // Push and pop together while empty: push taken, pop ignored
    sample_in = 32'h300; sample_valid_in = 1'b1; rd_en_in = 1'b1;
    step();
    check("emp_sim_vld", data_valid_out, 0);
    check("emp_sim_level", level_out, 1);
    // 40 push/pop pairs, pointers wrap twice over
    for (int i = 1; i < 40; i++) begin
      sample_in = 32'h300 + i;
      step();
      check("wrap_vld", data_valid_out, 1);
      check("wrap_data", data_out, 32'h300 + i - 1);
      check("wrap_level", level_out, 1);
    end
    sample_valid_in = 1'b0; rd_en_in = 1'b0;
    pop_check("wrap_last", 32'h300 + 39);
    rd_en_in = 1'b1;
    step();
    rd_en_in = 1'b0;
    check("wrap_empty_rd_vld", data_valid_out, 0);
    check("wrap_empty", empty_out, 1);

    // Capture length latched only on arm; rearm from DONE
    clear();
    arm(10'd2);
    capture_len_in = 10'd5;
    push(32'h1); push(32'h2);
    check("latch_done", done_out, 1);
    check("latch_level", level_out, 2);
    push(32'h3);
    check("done_ignore_level", level_out, 2);
    arm(10'd1);
    check("rearm_busy", busy_out, 1);
    check("rearm_keep_level", level_out, 2);
    push(32'h4);
    check("rearm_done", done_out, 1);
    check("rearm_level", level_out, 3);
    pop_check("rearm_data", 32'h1);

    // Clear beats arm and pop in the same cycle
    clear_in = 1'b1; arm_in = 1'b1; rd_en_in = 1'b1;
    step();
    idle_inputs();
    check("clrpri_busy", busy_out, 0);
    check("clrpri_done", done_out, 0);
    check("clrpri_level", level_out, 0);
    check("clrpri_vld", data_valid_out, 0);

`ifdef ADC_FIFO_WATERMARK_EN
    // Watermark interrupt
    watermark_in = 5'd8;
    arm(10'd0);
    for (int i = 0; i < 8; i++) push(i);
    check("wm_level8", level_out, 8);
    check("wm_irq_lag", irq_out, 0);
    step();
    check("wm_irq_hi", irq_out, 1);
    rd_en_in = 1'b1;
    step();
    rd_en_in = 1'b0;
    check("wm_level7", level_out, 7);
    check("wm_irq_lag_fall", irq_out, 1);
    step();
    check("wm_irq_lo", irq_out, 0);
    clear();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_sample_fifo.md
ADC_SAMPLE_FIFO -- requirements
Module: adc_sample_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the width of a decimated sample.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of 2); AW = log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1 bit: clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high; clock clk.
REQ-005 The block SHALL have port sample_in, input, DATA_WIDTH bits: decimator output sample.
REQ-006 The block SHALL have port sample_valid_in, input, 1 bit: one-cycle strobe qualifying sample_in.
REQ-007 The block SHALL have port arm_in, input, 1 bit: start-capture pulse.
REQ-008 The block SHALL have port capture_len_in, input, 10 bits: samples to capture; 0 = continuous.
REQ-009 The block SHALL have port clear_in, input, 1 bit: flush FIFO, clear flags, return to IDLE.
REQ-010 The block SHALL have port rd_en_in, input, 1 bit: host pop request.
REQ-011 The block SHALL have port data_out, output, DATA_WIDTH bits: popped sample.
REQ-012 The block SHALL have port data_valid_out, output, 1 bit: data_out valid this cycle.
REQ-013 The block SHALL have port level_out, output, AW+1 bits: current occupancy.
REQ-014 The block SHALL have ports empty_out and full_out, output, 1 bit each: occupancy == 0 and occupancy == DEPTH.
REQ-015 The block SHALL have port overflow_out, output, 1 bit: sticky sample-dropped flag.
REQ-016 The block SHALL have port busy_out, output, 1 bit: high in CAPTURE; and done_out, output, 1 bit: high in DONE.

Function
REQ-017 The FSM SHALL have three states, IDLE, CAPTURE and DONE, with these transitions: IDLE->CAPTURE on arm_in; CAPTURE->DONE when the accepted count equals a nonzero capture_len_in; DONE->CAPTURE on arm_in; any state->IDLE on clear_in.
REQ-018 capture_len_in SHALL be latched on arm_in and ignored at all other times.
REQ-019 Samples SHALL be written only in CAPTURE, with sample_valid_in high and FIFO not full.
REQ-020 A sample that arrives in CAPTURE while the FIFO is full SHALL be dropped, SHALL set overflow_out, and SHALL NOT increment the accepted count.
REQ-021 Samples arriving in IDLE or DONE SHALL be ignored silently, without setting overflow_out.
REQ-022 A pop SHALL occur when rd_en_in is high and the FIFO is not empty; data_out and data_valid_out SHALL be registered, with 1-cycle latency.
REQ-023 rd_en_in while empty SHALL hold data_valid_out low and SHALL NOT change the pointers.
REQ-024 A simultaneous push and pop SHALL leave level_out unchanged and SHALL be legal when full or empty: when full, the pop frees the slot and the push is accepted; when empty, the push is accepted and the pop is ignored.
REQ-025 The read and write pointers SHALL be AW bits wide and wrap modulo DEPTH; level_out SHALL be maintained as a counter.
REQ-026 On arm_in the accepted count SHALL reset to 0, and the FIFO contents SHALL be preserved.
REQ-027 clear_in SHALL take priority over arm_in, push and pop in the same cycle.
REQ-028 arm_in in CAPTURE SHALL restart the accepted count.

Reset
REQ-029 On rst the block SHALL enter IDLE, zero both pointers and level, and set data_out=0, data_valid_out=0, empty_out=1, full_out=0, overflow_out=0, busy_out=0, done_out=0.
REQ-030 rst SHALL take priority over all inputs; FIFO memory contents need not be reset.

Configuration
REQ-031 With ADC_FIFO_WATERMARK_EN defined, the block SHALL add input watermark_in (AW+1 bits) and output irq_out (1 bit), registered and defined as (level_out >= watermark_in AND watermark_in != 0) OR done_out, with reset value 0.
REQ-032 Without ADC_FIFO_WATERMARK_EN, watermark_in and irq_out SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 Package adc_fifo_pkg SHALL hold the FSM state encoding (IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2) and the default DATA_WIDTH/DEPTH constants.
REQ-034 Storage and pointers SHALL live in one sub-module, adc_sync_fifo; the FSM, capture counter and flags SHALL stay in the top level.

Verification
REQ-035 Reset test: assert rst mid-capture with level 5 -> next cycle IDLE, level_out=0, empty_out=1, overflow_out=0.
REQ-036 Capture test: arm with capture_len_in=4, drive 6 valid samples 0xA0..0xA5 -> FIFO holds 0xA0..0xA3, done_out=1, and 0xA4/0xA5 are ignored with overflow_out=0.
REQ-037 Overflow test: DEPTH=16, continuous mode, 17 samples without reads -> full_out=1, level_out=16, overflow_out=1, and 16 pops return samples 1..16.
REQ-038 Simultaneous push/pop test: while full, push and pop in the same cycle -> level stays 16, overflow_out stays 0, and the oldest sample appears on data_out one cycle later.
REQ-039 Wrap test: 40 interleaved push/pop pairs -> all data is returned in order, and an empty read gives data_valid_out=0.
REQ-040 Watermark test (ADC_FIFO_WATERMARK_EN): watermark_in=8 -> irq_out rises the cycle after level_out reaches 8 and falls after a pop to 7 when not DONE.
